// File: rtl/serial_digit_alu_pkg.sv
// Shared encodings for the multi-digit serial ALU: operation codes, FSM states
// and a small operation-class helper.
package serial_digit_alu_pkg;

  typedef logic [1:0] sda_op_t;
  typedef logic [1:0] sda_state_t;

  localparam sda_op_t SDA_OP_ADD = 2'd0;
  localparam sda_op_t SDA_OP_SUB = 2'd1;
  localparam sda_op_t SDA_OP_ROL = 2'd2;
  localparam sda_op_t SDA_OP_ROR = 2'd3;

  localparam sda_state_t SDA_IDLE = 2'd0;
  localparam sda_state_t SDA_RUN  = 2'd1;
  localparam sda_state_t SDA_DONE = 2'd2;

  // Decimal adjust applies only to the add/subtract family.
  function automatic logic sda_is_arith(input sda_op_t op);
    logic arith;
    case (op)
      SDA_OP_ROL: arith = 1'b0;
      SDA_OP_ROR: arith = 1'b0;
      default:    arith = 1'b1;
    endcase
    return arith;
  endfunction

endpackage

// File: rtl/serial_digit_alu_digit.sv
// One digit slice of the serial ALU: add/subtract with optional BCD adjust, or a
// one-bit rotate step where the carry register supplies the neighbouring bit.
module serial_digit_alu_digit
  import serial_digit_alu_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] digit_a,
  input  logic [DIGIT_W-1:0] digit_b,
  input  logic               cin,
  input  sda_op_t            op,
  input  logic               bcd,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               cout
);

  localparam logic [DIGIT_W-1:0] NINE_D = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] SIX_D  = DIGIT_W'(6);
  localparam logic [DIGIT_W:0]   NINE_S = (DIGIT_W + 1)'(9);

  logic               bcd_ok_s;
  logic [DIGIT_W-1:0] b_eff_s;
  logic [DIGIT_W:0]   sum_s;
  logic [DIGIT_W:0]   rot_s;

  // Digit arithmetic, decimal adjust and rotate step.
  always_comb begin
    bcd_ok_s  = bcd && (DIGIT_W == 4) && sda_is_arith(op);
    b_eff_s   = digit_b;
    rot_s     = '0;
    digit_out = '0;
    cout      = 1'b0;
    if (op == SDA_OP_SUB) begin
      // Nine's complement in decimal mode, one's complement in binary.
      b_eff_s = bcd_ok_s ? (NINE_D - digit_b) : ~digit_b;
    end else begin
      b_eff_s = digit_b;
    end
    sum_s = {1'b0, digit_a} + {1'b0, b_eff_s} + {{DIGIT_W{1'b0}}, cin};
    case (op)
      SDA_OP_ROL: begin
        rot_s     = {digit_a, cin};
        digit_out = rot_s[DIGIT_W-1:0];
        cout      = rot_s[DIGIT_W];
      end
      SDA_OP_ROR: begin
        rot_s     = {cin, digit_a};
        digit_out = rot_s[DIGIT_W:1];
        cout      = rot_s[0];
      end
      default: begin
        if (bcd_ok_s && (sum_s > NINE_S)) begin
          digit_out = sum_s[DIGIT_W-1:0] + SIX_D;
          cout      = 1'b1;
        end else begin
          digit_out = sum_s[DIGIT_W-1:0];
          cout      = sum_s[DIGIT_W];
        end
      end
    endcase
  end

endmodule

// File: rtl/serial_digit_alu.sv
// Multi-digit ALU sequencer: latches a request, walks one digit per clock through
// a shared digit slice, and presents the whole-word result over valid/ready.
module serial_digit_alu
  import serial_digit_alu_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int DIGITS  = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_op,
  input  logic                        in_bcd,
  input  logic                        in_cin,
  input  logic [DIGITS*DIGIT_W-1:0]   in_a,
  input  logic [DIGITS*DIGIT_W-1:0]   in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DIGITS*DIGIT_W-1:0]   out_result,
  output logic                        out_carry,
  output logic                        out_zero
);

  localparam int N     = DIGITS * DIGIT_W;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  sda_state_t       state_r;
  logic [IDX_W-1:0] idx_r;
  sda_op_t          op_r;
  logic             bcd_r;
  logic             carry_r;
  logic [N-1:0]     a_r;
  logic [N-1:0]     b_r;
  logic [N-1:0]     res_r;
  logic [N-1:0]     out_result_r;
  logic             out_carry_r;
  logic             out_zero_r;
  logic             out_valid_r;

  logic               msd_first_s;
  logic [DIGIT_W-1:0] digit_a_s;
  logic [DIGIT_W-1:0] digit_b_s;
  logic [DIGIT_W-1:0] digit_out_s;
  logic               digit_cout_s;
  logic [N-1:0]       digit_ext_s;
  logic [N-1:0]       a_next_s;
  logic [N-1:0]       b_next_s;
  logic [N-1:0]       res_next_s;

  assign in_ready   = (state_r == SDA_IDLE);
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_carry  = out_carry_r;
  assign out_zero   = out_zero_r;

  // Operand digit selection: ROR walks from the most significant digit.
  always_comb begin
    msd_first_s = (op_r == SDA_OP_ROR);
    if (msd_first_s) begin
      digit_a_s = a_r[N-1 -: DIGIT_W];
      digit_b_s = b_r[N-1 -: DIGIT_W];
      a_next_s  = a_r << DIGIT_W;
      b_next_s  = b_r << DIGIT_W;
    end else begin
      digit_a_s = a_r[DIGIT_W-1:0];
      digit_b_s = b_r[DIGIT_W-1:0];
      a_next_s  = a_r >> DIGIT_W;
      b_next_s  = b_r >> DIGIT_W;
    end
  end

  serial_digit_alu_digit #(
    .DIGIT_W (DIGIT_W)
  ) u_digit (
    .digit_a   (digit_a_s),
    .digit_b   (digit_b_s),
    .cin       (carry_r),
    .op        (op_r),
    .bcd       (bcd_r),
    .digit_out (digit_out_s),
    .cout      (digit_cout_s)
  );

  // Result assembly: the new digit enters at the end opposite the walk direction.
  always_comb begin
    digit_ext_s                = '0;
    digit_ext_s[DIGIT_W-1:0]   = digit_out_s;
    if (msd_first_s) begin
      res_next_s = (res_r << DIGIT_W) | digit_ext_s;
    end else begin
      res_next_s = (res_r >> DIGIT_W) | (digit_ext_s << (N - DIGIT_W));
    end
  end

  // Sequencer FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= SDA_IDLE;
      idx_r        <= '0;
      op_r         <= SDA_OP_ADD;
      bcd_r        <= 1'b0;
      carry_r      <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
      res_r        <= '0;
      out_result_r <= '0;
      out_carry_r  <= 1'b0;
      out_zero_r   <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      case (state_r)
        SDA_IDLE: begin
          if (in_valid) begin
            op_r    <= in_op;
            bcd_r   <= in_bcd;
            carry_r <= in_cin;
            a_r     <= in_a;
            b_r     <= in_b;
            res_r   <= '0;
            idx_r   <= '0;
            state_r <= SDA_RUN;
          end
        end
        SDA_RUN: begin
          a_r     <= a_next_s;
          b_r     <= b_next_s;
          res_r   <= res_next_s;
          carry_r <= digit_cout_s;
          idx_r   <= idx_r + 1'b1;
          if (idx_r == LAST_IDX) begin
            // Only the completed word is ever exposed on the outputs.
            out_result_r <= res_next_s;
            out_carry_r  <= digit_cout_s;
            out_zero_r   <= (res_next_s == '0);
            out_valid_r  <= 1'b1;
            state_r      <= SDA_DONE;
          end
        end
        SDA_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= SDA_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= SDA_IDLE;
        end
      endcase
    end
  end

endmodule
